// File: rtl/exec_pkg.sv
// Shared opcode constants, funct3 encodings and the registered result record
// for the execute stage.
package exec_pkg;

    // The result record is sized for the widest supported configuration.
    localparam int XLEN_MAX = 64;
    localparam int RA_MAX   = 16;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SLL  = 3'b001,
        ALU_SLT  = 3'b010,
        ALU_SLTU = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_SR   = 3'b101,
        ALU_OR   = 3'b110,
        ALU_AND  = 3'b111
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_EQ  = 3'b000,
        BR_NE  = 3'b001,
        BR_LT  = 3'b100,
        BR_GE  = 3'b101,
        BR_LTU = 3'b110,
        BR_GEU = 3'b111
    } br_op_e;

    typedef struct packed {
        logic [XLEN_MAX-1:0] result;
        logic [XLEN_MAX-1:0] mem_addr;
        logic [XLEN_MAX-1:0] store_data;
        logic                branch_taken;
        logic [XLEN_MAX-1:0] branch_target;
        logic [RA_MAX-1:0]   rd;
        logic                reg_write;
        logic                illegal;
    } exec_out_t;

endpackage

// File: rtl/regfile_bp.sv
// Two-read, one-write register file; a same-cycle write is bypassed to the
// read ports, and x0 is hardwired to zero.
module regfile_bp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int RAW  = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wen,
    input  logic [RAW-1:0]  waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [RAW-1:0]  raddr1,
    input  logic [RAW-1:0]  raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] mem [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else if (wen && waddr != '0) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (raddr1 != '0) rdata1 = (wen && waddr == raddr1) ? wdata : mem[raddr1];
        if (raddr2 != '0) rdata2 = (wen && waddr == raddr2) ? wdata : mem[raddr2];
    end

endmodule

// File: rtl/exec_stage_pipe.sv
// Execute stage: operand fetch with forwarding, integer ALU / branch unit, and
// a single registered output slot with valid/ready back-pressure.
module exec_stage_pipe
    import exec_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int RAW  = $clog2(NREGS),
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [RAW-1:0]  rs1,
    input  logic [RAW-1:0]  rs2,
    input  logic [RAW-1:0]  rd,
    input  logic [XLEN-1:0] immediate,
    input  logic            alu_src,
    input  logic [XLEN-1:0] pc,
    input  logic            wb_en,
    input  logic [RAW-1:0]  wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] store_data,
    output logic            branch_taken,
    output logic [XLEN-1:0] branch_target,
    output logic [RAW-1:0]  out_rd,
    output logic            out_reg_write,
    output logic            illegal
);

    exec_out_t       out_q, nxt;
    logic            accept;
    logic [XLEN-1:0] rf1, rf2, a, b, opb, alu_r;
    logic [SHW-1:0]  shamt;
    logic            fwd_ok, br_cond, br_ill;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    regfile_bp #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
        .clk    (clk),
        .rst    (rst),
        .wen    (wb_en),
        .waddr  (wb_rd),
        .wdata  (wb_data),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rf1),
        .rdata2 (rf2)
    );

    // The held result is younger than anything on the write-back port, so it wins.
    assign fwd_ok = out_valid && out_q.reg_write;
    assign a      = (fwd_ok && rs1 != '0 && out_rd == rs1) ? result : rf1;
    assign b      = (fwd_ok && rs2 != '0 && out_rd == rs2) ? result : rf2;
    assign opb    = alu_src ? immediate : b;
    assign shamt  = opb[SHW-1:0];

    always_comb begin
        alu_r = '0;
        case (alu_op_e'(funct3))
            ALU_ADD:  alu_r = (opcode == OPC_OP && funct7[5]) ? a - opb : a + opb;
            ALU_SLL:  alu_r = a << shamt;
            ALU_SLT:  alu_r = {{(XLEN-1){1'b0}}, $signed(a) < $signed(opb)};
            ALU_SLTU: alu_r = {{(XLEN-1){1'b0}}, a < opb};
            ALU_XOR:  alu_r = a ^ opb;
            ALU_SR:   alu_r = funct7[5] ? XLEN'($signed(a) >>> shamt) : a >> shamt;
            ALU_OR:   alu_r = a | opb;
            ALU_AND:  alu_r = a & opb;
            default:  alu_r = '0;
        endcase
    end

    // Branches always compare register values, regardless of alu_src.
    always_comb begin
        br_cond = 1'b0;
        br_ill  = 1'b0;
        case (br_op_e'(funct3))
            BR_EQ:   br_cond = (a == b);
            BR_NE:   br_cond = (a != b);
            BR_LT:   br_cond = ($signed(a) < $signed(b));
            BR_GE:   br_cond = ($signed(a) >= $signed(b));
            BR_LTU:  br_cond = (a < b);
            BR_GEU:  br_cond = (a >= b);
            default: br_ill  = 1'b1;
        endcase
    end

    always_comb begin
        nxt    = '0;
        nxt.rd = RA_MAX'(rd);
        case (opcode)
            OPC_OP, OPC_OPIMM: begin
                nxt.result    = XLEN_MAX'(alu_r);
                nxt.reg_write = 1'b1;
            end
            OPC_LOAD: begin
                nxt.mem_addr  = XLEN_MAX'(a + immediate);
                nxt.reg_write = 1'b1;
            end
            OPC_STORE: begin
                nxt.mem_addr   = XLEN_MAX'(a + immediate);
                nxt.store_data = XLEN_MAX'(b);
            end
            OPC_BRANCH: begin
                nxt.illegal       = br_ill;
                nxt.branch_taken  = br_cond && !br_ill;
                nxt.branch_target = XLEN_MAX'(pc + immediate);
            end
            OPC_JAL: begin
                nxt.branch_taken  = 1'b1;
                nxt.branch_target = XLEN_MAX'(pc + immediate);
                nxt.result        = XLEN_MAX'(pc + XLEN'(4));
                nxt.reg_write     = 1'b1;
            end
            OPC_JALR: begin
                nxt.branch_taken  = 1'b1;
                nxt.branch_target = XLEN_MAX'((a + immediate) & ~XLEN'(1));
                nxt.result        = XLEN_MAX'(pc + XLEN'(4));
                nxt.reg_write     = 1'b1;
            end
            OPC_LUI: begin
                nxt.result    = XLEN_MAX'(immediate << 12);
                nxt.reg_write = 1'b1;
            end
            default: nxt.illegal = 1'b1;
        endcase
        if (nxt.illegal) begin
            nxt         = '0;
            nxt.illegal = 1'b1;
        end
        if (rd == '0) nxt.reg_write = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_q     <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_q     <= nxt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign result        = out_q.result[XLEN-1:0];
    assign mem_addr      = out_q.mem_addr[XLEN-1:0];
    assign store_data    = out_q.store_data[XLEN-1:0];
    assign branch_taken  = out_q.branch_taken;
    assign branch_target = out_q.branch_target[XLEN-1:0];
    assign out_rd        = out_q.rd[RAW-1:0];
    assign out_reg_write = out_q.reg_write;
    assign illegal       = out_q.illegal;

    // Upper record bits stay zero below the maximum width; funct7 only needs bit 5.
    logic unused_bits;
    assign unused_bits = ^{out_q, funct7[6], funct7[4:0]};

endmodule
